// File: rtl/rgb_channel_merge_pkg.sv
// Shared pixel constants and the normalise/narrow helper used by the RGB merge path.
// Build option: define MERGE_SATURATE_EN to clamp the narrowed value instead of wrapping.
package rgb_merge_pkg;

    localparam int CH_W   = 8;
    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;
    localparam int NUM_CH = 3;
    localparam int NORM_W = 32;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    // Callers sign-extend their result to NORM_W bits before handing it in.
    function automatic logic [CH_W-1:0] normalise(input logic signed [NORM_W-1:0] x,
                                                  input int shift);
        logic signed [NORM_W-1:0] shifted;
        shifted = x >>> shift;
`ifdef MERGE_SATURATE_EN
        if (shifted < 0) begin
            return '0;
        end else if (shifted > 32'sd255) begin
            return '1;
        end else begin
            return shifted[CH_W-1:0];
        end
`else
        return shifted[CH_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/rgb_channel_merge_if.sv
// Channel-result inputs and packed-pixel outputs of the RGB merge block.
interface rgb_channel_merge_if #(
    parameter int CWIDTH = 20,
    parameter int DWIDTH = 24
);
    logic [CWIDTH-1:0] r_in;
    logic              r_valid;
    logic [CWIDTH-1:0] g_in;
    logic              g_valid;
    logic [CWIDTH-1:0] b_in;
    logic              b_valid;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid_out;
    logic              overflow;

    modport master (
        output r_in, r_valid, g_in, g_valid, b_in, b_valid,
        input  data_out, data_valid_out, overflow
    );

    modport slave (
        input  r_in, r_valid, g_in, g_valid, b_in, b_valid,
        output data_out, data_valid_out, overflow
    );
endinterface

// File: rtl/rgb_channel_merge_skew_fifo.sv
// Per-channel skew FIFO: registered write, combinational head read, empty/full flags.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module merge_skew_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             wrEn;
    logic             rdEn;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign rdData_o = mem_q[rdPtr_q];
    assign rdEn     = pop_i && !empty_o;
    assign wrEn     = push_i && (!full_o || rdEn);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (rdEn) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({wrEn, rdEn})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/rgb_channel_merge.sv
// Merges skewed R/G/B convolution result streams into one packed 24-bit pixel stream.
// Narrowing behaviour follows MERGE_SATURATE_EN (see rgb_merge_pkg).
module rgb_channel_merge
    import rgb_merge_pkg::*;
#(
    parameter int CWIDTH     = 20,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DWIDTH     = 24
) (
    input logic                clock,
    input logic                reset,
    rgb_channel_merge_if.slave bus
);

    logic [NUM_CH-1:0] pushVec;
    logic [NUM_CH-1:0] emptyVec;
    logic [NUM_CH-1:0] fullVec;
    logic [CWIDTH-1:0] headData [NUM_CH];
    logic              popEn;
    logic              dropAny;
    pixel_t            pixel;

    logic [DWIDTH-1:0] dataOut_q, dataOut_d;
    logic              dataValid_q, dataValid_d;
    logic              overflow_q, overflow_d;

    assign pushVec[CH_R] = bus.r_valid;
    assign pushVec[CH_G] = bus.g_valid;
    assign pushVec[CH_B] = bus.b_valid;

    merge_skew_fifo #(.WIDTH(CWIDTH), .DEPTH(FIFO_DEPTH)) uFifoR (
        .clock    (clock),
        .reset    (reset),
        .push_i   (pushVec[CH_R]),
        .wrData_i (bus.r_in),
        .pop_i    (popEn),
        .rdData_o (headData[CH_R]),
        .empty_o  (emptyVec[CH_R]),
        .full_o   (fullVec[CH_R])
    );

    merge_skew_fifo #(.WIDTH(CWIDTH), .DEPTH(FIFO_DEPTH)) uFifoG (
        .clock    (clock),
        .reset    (reset),
        .push_i   (pushVec[CH_G]),
        .wrData_i (bus.g_in),
        .pop_i    (popEn),
        .rdData_o (headData[CH_G]),
        .empty_o  (emptyVec[CH_G]),
        .full_o   (fullVec[CH_G])
    );

    merge_skew_fifo #(.WIDTH(CWIDTH), .DEPTH(FIFO_DEPTH)) uFifoB (
        .clock    (clock),
        .reset    (reset),
        .push_i   (pushVec[CH_B]),
        .wrData_i (bus.b_in),
        .pop_i    (popEn),
        .rdData_o (headData[CH_B]),
        .empty_o  (emptyVec[CH_B]),
        .full_o   (fullVec[CH_B])
    );

    // Pop only when every channel has a sample; a full FIFO is rescued by that same pop.
    assign popEn   = ~|emptyVec;
    assign dropAny = (|(pushVec & fullVec)) & ~popEn;

    always_comb begin
        pixel.r     = normalise(NORM_W'(signed'(headData[CH_R])), SHIFT);
        pixel.g     = normalise(NORM_W'(signed'(headData[CH_G])), SHIFT);
        pixel.b     = normalise(NORM_W'(signed'(headData[CH_B])), SHIFT);
        dataOut_d   = popEn ? DWIDTH'(pixel) : dataOut_q;
        dataValid_d = popEn;
        overflow_d  = overflow_q | dropAny;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.data_out       = dataOut_q;
    assign bus.data_valid_out = dataValid_q;
    assign bus.overflow       = overflow_q;

endmodule

// File: doc/rgb_channel_merge.md
# rgb_channel_merge

Recombines the three independent per-channel convolution result streams (R, G, B) into one 24-bit RGB pixel stream. It absorbs latency skew between channels with small per-channel FIFOs, normalises each wide signed result to 8 bits, and emits a packed pixel only when all three channels have a sample available. It sits directly downstream of the per-channel conv5x5 engines and is the inverse of the split that feeds them.

## Interface
- CWIDTH, 20, width of each signed channel result (two's complement)
- SHIFT, 8, arithmetic right shift applied to each channel result before narrowing
- FIFO_DEPTH, 8, entries per channel skew FIFO (power of two, ≥2)
- DWIDTH, 24, packed output pixel width (fixed 3×8)

- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- r_in  in  CWIDTH  R channel result
- r_valid  in  1  r_in valid this cycle
- g_in  in  CWIDTH  G channel result
- g_valid  in  1  g_in valid this cycle
- b_in  in  CWIDTH  B channel result
- b_valid  in  1  b_in valid this cycle
- data_out  out  DWIDTH  packed pixel {R[23:16], G[15:8], B[7:0]}
- data_valid_out  out  1  data_out valid, one-cycle qualifier
- overflow  out  1  sticky: a sample was dropped because its FIFO was full

## Operation
- Valid-only streaming; no backpressure toward sources or from the sink.
- Each *_valid pushes the corresponding *_in into its channel FIFO.
- Pop condition: all three FIFOs non-empty → pop one entry from each in the same cycle.
- Popped triple is normalised per channel, packed, registered into data_out; data_valid_out pulses high that cycle.
- Normalisation: x >>> SHIFT (sign-preserving), then narrowed to 8 bits per Configuration.
- Push to a full FIFO with no pop that cycle: sample dropped, overflow set; overflow clears only on reset.
- Push and pop on a full FIFO in the same cycle: both succeed, no overflow.
- Push and pop on an empty FIFO in the same cycle: the pop is not taken (empty at pop decision); the push is stored.
- Channel order is preserved; no reordering or duplication.

## Timing
- Reset (async assert, release synchronous to clock): all FIFOs empty, data_out = 0, data_valid_out = 0, overflow = 0.
- Reset mid-stream: all buffered samples discarded; no partial pixel is emitted after release.
- Latency: all three valids in cycle N with empty FIFOs → data_valid_out high in cycle N+2.
- Skewed arrival: output occurs 2 cycles after the latest of the three channel pushes.
- Throughput: one pixel per cycle sustained when all channels deliver one sample per cycle.
- data_out holds its last value when data_valid_out is low.

## Configuration
- MERGE_SATURATE_EN defined: shifted value clamped, < 0 → 0x00, > 255 → 0xFF, otherwise low 8 bits.
- MERGE_SATURATE_EN undefined: bits [SHIFT+7:SHIFT] of the input taken directly (wrap-around truncation).

## Structure
- Package rgb_merge_pkg: CH_W = 8, channel index constants CH_R = 0, CH_G = 1, CH_B = 2, and the normalise/saturate function shared with other pixel post-processing blocks.
- Sub-module merge_skew_fifo (CWIDTH × FIFO_DEPTH, registered write, empty/full flags, push/pop). Instantiated three times.
- Top level contains only the pop decision, normalisation, output register, and overflow flag.

## Test plan
- Aligned stream, SHIFT = 8: R = 0x01200, G = 0x00800, B = 0x0FF00 in the same cycle → two cycles later data_out = 0x1208FF, one valid pulse.
- Skew: R at cycle 0, G at cycle 3, B at cycle 5 → a single valid pulse at cycle 7, correct packing.
- Saturation (MERGE_SATURATE_EN): R = -0x00100 → R byte 0x00; R = 0x12300 → R byte 0xFF. Without the macro, same inputs → 0xFF and 0x23.
- Overflow: FIFO_DEPTH = 8, push 9 R samples with G and B idle → overflow = 1 after the 9th push. Then feed 8 G and 8 B samples → exactly 8 pixels carrying the first 8 R samples.
- Full-FIFO push+pop: hold R full, deliver G and B so a pop coincides with an R push → overflow stays 0 and the pixel count matches the push count.
- Reset mid-stream: assert reset with 3 R samples buffered, release, then send one aligned triple → exactly one pixel from the new triple, outputs 0 during reset.
